regfile_scoreboard: RTL and testbench

- Architectural integer register file (x0..x31) with a per-register reservation scoreboard.
- Sits opposite the decode stage on its register-read/reserve interface. It answers combinational source reads and raises a source-busy stall.
- Accepts rd reservations from decode and releases them on writeback.
- Handles RAW hazards and multiple outstanding writers to one rd (WAW) with saturating per-register pending counters.

---
 rtl/regfile_scoreboard.sv | 131 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file x0..x31 with per-register saturating pending-write counters for RAW/WAW stalls.
// Optional same-cycle writeback-to-read forwarding when REGFILE_WB_BYPASS_EN is defined.
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      r0num_i,
    input  logic            r0valid_i,
    input  logic [4:0]      r1num_i,
    input  logic            r1valid_i,
    input  logic [4:0]      rdnum_i,
    input  logic            rdreserve_i,
    output logic [XLEN-1:0] r0data_o,
    output logic [XLEN-1:0] r1data_o,
    output logic            rsreserved_o,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_num_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            err_o
);

    localparam int unsigned NREG = 32;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [XLEN-1:0]  regs    [NREG];
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];

    logic [NREG-1:0] inc_c;
    logic [NREG-1:0] dec_c;
    logic            wb_en_c;
    logic            err_set_c;
    logic            busy0_c;
    logic            busy1_c;
    logic            sat_c;

    assign wb_en_c = wb_valid_i && (wb_num_i != 5'd0);

    // One-hot reserve/release strobes; x0 never gets either.
    always_comb begin
        inc_c = '0;
        dec_c = '0;
        if (rdreserve_i && (rdnum_i != 5'd0)) begin
            inc_c[rdnum_i] = 1'b1;
        end
        if (wb_en_c) begin
            dec_c[wb_num_i] = 1'b1;
        end
    end

    // Counter next-state; flush overrides any reserve/release and masks their errors.
    always_comb begin
        err_set_c = 1'b0;
        for (int n = 0; n < NREG; n++) begin
            cnt_nxt[n] = cnt[n];
            if (n == 0 || flush_i) begin
                cnt_nxt[n] = CNT_ZERO;
            end else if (inc_c[n] && !dec_c[n]) begin
                if (cnt[n] == CNT_MAX) begin
                    err_set_c = 1'b1;
                end else begin
                    cnt_nxt[n] = cnt[n] + CNT_ONE;
                end
            end else if (dec_c[n] && !inc_c[n]) begin
                if (cnt[n] == CNT_ZERO) begin
                    err_set_c = 1'b1;
                end else begin
                    cnt_nxt[n] = cnt[n] - CNT_ONE;
                end
            end
        end
    end

    // Register file, counters and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NREG; n++) begin
                regs[n] <= '0;
                cnt[n]  <= '0;
            end
            err_o <= 1'b0;
        end else begin
            if (wb_en_c) begin
                regs[wb_num_i] <= wb_data_i;
            end
            for (int n = 0; n < NREG; n++) begin
                cnt[n] <= cnt_nxt[n];
            end
            if (err_set_c) begin
                err_o <= 1'b1;
            end
        end
    end

    // Source read ports.
    always_comb begin
        r0data_o = (r0num_i == 5'd0) ? '0 : regs[r0num_i];
        r1data_o = (r1num_i == 5'd0) ? '0 : regs[r1num_i];
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_en_c && (wb_num_i == r0num_i)) begin
            r0data_o = wb_data_i;
        end
        if (wb_en_c && (wb_num_i == r1num_i)) begin
            r1data_o = wb_data_i;
        end
`endif
    end

    // Stall; the rd term ignores rdreserve_i so decode can gate its reserve with it.
    always_comb begin
        busy0_c = r0valid_i && (cnt[r0num_i] != CNT_ZERO);
        busy1_c = r1valid_i && (cnt[r1num_i] != CNT_ZERO);
`ifdef REGFILE_WB_BYPASS_EN
        // Last outstanding writer retiring now releases the source this cycle.
        if (dec_c[r0num_i] && (cnt[r0num_i] == CNT_ONE) && !inc_c[r0num_i]) begin
            busy0_c = 1'b0;
        end
        if (dec_c[r1num_i] && (cnt[r1num_i] == CNT_ONE) && !inc_c[r1num_i]) begin
            busy1_c = 1'b0;
        end
`endif
        sat_c        = (rdnum_i != 5'd0) && (cnt[rdnum_i] == CNT_MAX);
        rsreserved_o = busy0_c || busy1_c || sat_c;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic against a queue-free array model.
module tb_regfile_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  r0num_i, r1num_i, rdnum_i, wb_num_i;
    logic        r0valid_i, r1valid_i, rdreserve_i, wb_valid_i, flush_i;
    logic [31:0] wb_data_i;
    logic [31:0] r0data_o, r1data_o;
    logic        rsreserved_o, err_o;

    int          cnt_m [32];
    logic [31:0] reg_m [32];
    logic        err_m;
    int          checks;
    int          passed;

    regfile_scoreboard #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .r0num_i(r0num_i), .r0valid_i(r0valid_i),
        .r1num_i(r1num_i), .r1valid_i(r1valid_i),
        .rdnum_i(rdnum_i), .rdreserve_i(rdreserve_i),
        .r0data_o(r0data_o), .r1data_o(r1data_o), .rsreserved_o(rsreserved_o),
        .wb_valid_i(wb_valid_i), .wb_num_i(wb_num_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] n);
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_valid_i && wb_num_i == n && n != 0) return wb_data_i;
`endif
        return (n == 0) ? 32'd0 : reg_m[n];
    endfunction

    // A source is busy while writers are outstanding; with forwarding, judged on the count after this cycle.
    function automatic logic src_busy(input logic [4:0] n, input logic v);
        int c;
        int after;
        c = (n == 0) ? 0 : cnt_m[n];
        after = c;
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_valid_i && wb_num_i == n) after = after - 1;
        if (rdreserve_i && rdnum_i == n) after = after + 1;
`endif
        return v && c != 0 && after != 0;
    endfunction

    function automatic logic exp_stall();
        return src_busy(r0num_i, r0valid_i) || src_busy(r1num_i, r1valid_i)
            || (rdnum_i != 0 && cnt_m[rdnum_i] == MAXC);
    endfunction

    task automatic idle();
        r0num_i = 0; r0valid_i = 0; r1num_i = 0; r1valid_i = 0;
        rdnum_i = 0; rdreserve_i = 0; wb_valid_i = 0; wb_num_i = 0;
        wb_data_i = 0; flush_i = 0;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < 32; n++) begin
                cnt_m[n] = 0;
                reg_m[n] = 0;
            end
            err_m = 0;
        end else begin
            if (wb_valid_i && wb_num_i != 0) reg_m[wb_num_i] = wb_data_i;
            for (int n = 1; n < 32; n++) begin
                bit inc;
                bit dec;
                inc = rdreserve_i && rdnum_i == n;
                dec = wb_valid_i && wb_num_i == n;
                if (flush_i) cnt_m[n] = 0;
                else if (inc && !dec) begin
                    if (cnt_m[n] == MAXC) err_m = 1; else cnt_m[n]++;
                end else if (dec && !inc) begin
                    if (cnt_m[n] == 0) err_m = 1; else cnt_m[n]--;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        r0num_i = 5; r0valid_i = 1; r1num_i = 0; r1valid_i = 1;
        #1;
        checks++; if (r0data_o !== 32'd0) $display("FAIL reset_r0data got=%h exp=0", r0data_o); else passed++;
        checks++; if (r1data_o !== 32'd0) $display("FAIL reset_r1data got=%h exp=0", r1data_o); else passed++;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", rsreserved_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_o); else passed++;
    endtask

    task automatic test_raw();
        idle(); rdnum_i = 3; rdreserve_i = 1; #1;
        tick();
        idle(); r0num_i = 3; r0valid_i = 1; #1;
        checks++; if (rsreserved_o !== 1'b1) $display("FAIL raw_pending_stall got=%b exp=1", rsreserved_o); else passed++;
        tick();
        wb_valid_i = 1; wb_num_i = 3; wb_data_i = 32'hDEADBEEF; #1;
        checks++; if (rsreserved_o !== exp_stall()) $display("FAIL raw_wb_stall got=%b exp=%b", rsreserved_o, exp_stall()); else passed++;
        checks++; if (r0data_o !== exp_rd(3)) $display("FAIL raw_wb_data got=%h exp=%h", r0data_o, exp_rd(3)); else passed++;
        tick();
        idle(); r0num_i = 3; r0valid_i = 1; #1;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL raw_after_stall got=%b exp=0", rsreserved_o); else passed++;
        checks++; if (r0data_o !== 32'hDEADBEEF) $display("FAIL raw_after_data got=%h exp=deadbeef", r0data_o); else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            idle(); rdnum_i = 7; rdreserve_i = 1; #1;
            tick();
        end
        idle(); rdnum_i = 7; #1;
        checks++; if (rsreserved_o !== 1'b1) $display("FAIL sat_rd_stall got=%b exp=1", rsreserved_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL sat_err_before got=%b exp=0", err_o); else passed++;
        rdreserve_i = 1; #1;
        tick();
        idle(); #1;
        checks++; if (err_o !== 1'b1) $display("FAIL sat_err_after got=%b exp=1", err_o); else passed++;
        for (int i = 0; i < 3; i++) begin
            idle(); r0num_i = 7; r0valid_i = 1; #1;
            checks++; if (rsreserved_o !== 1'b1) $display("FAIL sat_drain_%0d got=%b exp=1", i, rsreserved_o); else passed++;
            wb_valid_i = 1; wb_num_i = 7; wb_data_i = 32'h7000_0000 + 32'(i); #1;
            tick();
        end
        idle(); r0num_i = 7; r0valid_i = 1; rdnum_i = 7; #1;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL sat_drained_stall got=%b exp=0", rsreserved_o); else passed++;
        checks++; if (r0data_o !== 32'h7000_0002) $display("FAIL sat_drained_data got=%h exp=70000002", r0data_o); else passed++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        rdnum_i = 9; rdreserve_i = 1; #1;
        tick();
        idle(); rdnum_i = 9; rdreserve_i = 1; wb_valid_i = 1; wb_num_i = 9;
        wb_data_i = 32'h55AA_1234; r1num_i = 9; r1valid_i = 1; #1;
        checks++; if (rsreserved_o !== 1'b1) $display("FAIL same_cycle_stall got=%b exp=1", rsreserved_o); else passed++;
        tick();
        idle(); r1num_i = 9; r1valid_i = 1; #1;
        checks++; if (rsreserved_o !== 1'b1) $display("FAIL same_after_stall got=%b exp=1", rsreserved_o); else passed++;
        checks++; if (r1data_o !== 32'h55AA_1234) $display("FAIL same_after_data got=%h exp=55aa1234", r1data_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL same_err got=%b exp=0", err_o); else passed++;
    endtask

    task automatic test_flush();
        idle(); rdnum_i = 4; rdreserve_i = 1; #1; tick();
        idle(); rdnum_i = 6; rdreserve_i = 1; #1; tick();
        idle(); rdnum_i = 8; rdreserve_i = 1; flush_i = 1; #1; tick();
        idle(); r0num_i = 4; r0valid_i = 1; r1num_i = 6; r1valid_i = 1; rdnum_i = 8; #1;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL flush_stall got=%b exp=0", rsreserved_o); else passed++;
        r0num_i = 8; r1num_i = 9; #1;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL flush_stall2 got=%b exp=0", rsreserved_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL flush_err got=%b exp=0", err_o); else passed++;
    endtask

    task automatic test_x0_and_underflow();
        idle(); wb_valid_i = 1; wb_num_i = 0; wb_data_i = 32'h1234; rdnum_i = 0; rdreserve_i = 1; #1;
        checks++; if (r0data_o !== 32'd0) $display("FAIL x0_wb_cycle_data got=%h exp=0", r0data_o); else passed++;
        tick();
        idle(); r0valid_i = 1; r1valid_i = 1; #1;
        checks++; if (r0data_o !== 32'd0) $display("FAIL x0_data got=%h exp=0", r0data_o); else passed++;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL x0_stall got=%b exp=0", rsreserved_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL x0_err got=%b exp=0", err_o); else passed++;
        idle(); wb_valid_i = 1; wb_num_i = 10; wb_data_i = 32'hCAFE_0010; #1;
        tick();
        idle(); r0num_i = 10; r0valid_i = 1; #1;
        checks++; if (r0data_o !== 32'hCAFE_0010) $display("FAIL under_data got=%h exp=cafe0010", r0data_o); else passed++;
        checks++; if (err_o !== 1'b1) $display("FAIL under_err got=%b exp=1", err_o); else passed++;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL under_stall got=%b exp=0", rsreserved_o); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            r0num_i   = 5'($urandom_range(0, 7));
            r0valid_i = 1'($urandom);
            r1num_i   = 5'($urandom_range(0, 7));
            r1valid_i = 1'($urandom);
            rdnum_i   = 5'($urandom_range(0, 7));
            wb_valid_i = ($urandom_range(0, 2) == 0);
            wb_num_i  = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            flush_i   = ($urandom_range(0, 40) == 0);
            #1;
            if (!exp_stall() && $urandom_range(0, 1) == 1) rdreserve_i = 1;
            #1;
            checks++; if (r0data_o !== exp_rd(r0num_i)) $display("FAIL rand_r0data cyc=%0d got=%h exp=%h", cyc, r0data_o, exp_rd(r0num_i)); else passed++;
            checks++; if (r1data_o !== exp_rd(r1num_i)) $display("FAIL rand_r1data cyc=%0d got=%h exp=%h", cyc, r1data_o, exp_rd(r1num_i)); else passed++;
            checks++; if (rsreserved_o !== exp_stall()) $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, rsreserved_o, exp_stall()); else passed++;
            tick();
            checks++; if (err_o !== err_m) $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err_o, err_m); else passed++;
        end
        rst = 1; idle(); tick(); rst = 0;
        r0num_i = 3; r0valid_i = 1; r1num_i = 7; r1valid_i = 1; #1;
        checks++; if (rsreserved_o !== 1'b0) $display("FAIL midreset_stall got=%b exp=0", rsreserved_o); else passed++;
        checks++; if (r1data_o !== 32'd0) $display("FAIL midreset_data got=%h exp=0", r1data_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL midreset_err got=%b exp=0", err_o); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        err_m  = 0;
        rst    = 1;
        idle();
        test_reset();
        test_raw();
        test_saturation();
        test_same_cycle();
        test_flush();
        test_x0_and_underflow();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
